// File: rtl/counter_mode_unit_if.sv
// Operand/result bundle of counter_mode_unit: mode select and operands in, registered result and flags out.
// The master drives en/sel/a/b; the slave (the unit) returns dout/tc/cb.
interface counter_mode_unit_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 4
);
  // No valid/ready pair: en is a per-cycle qualifier sampled with sel/a/b on every rising clk,
  // and dout/tc/cb reflect that sample after the edge; the unit can never stall the master.
  logic             en;
  logic [2:0]       sel;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic [OUT_W-1:0] dout;
  logic             tc;
  logic             cb;

  modport master (
    output en, sel, a, b,
    input  dout, tc, cb
  );

  modport slave (
    input  en, sel, a, b,
    output dout, tc, cb
  );
endinterface

// File: rtl/counter_mode_unit.sv
// Multi-mode register unit: count up/down, hold, load, add, subtract, clear, with tc/cb flag pulses.
// Define COUNTER_SATURATE_EN to clamp counts and SUB at the range limits instead of wrapping.
module counter_mode_unit #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 4,
  parameter int STEP  = 1
) (
  input  logic                clk,
  input  logic                rst,
  counter_mode_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_CNT_UP = 3'b000,
    MODE_HOLD   = 3'b001,
    MODE_ADD    = 3'b010,
    MODE_SUB    = 3'b011,
    MODE_CNT_DN = 3'b100,
    MODE_LOAD   = 3'b101,
    MODE_CLEAR  = 3'b110,
    MODE_RESV   = 3'b111
  } mode_t;

  generate
    if (OUT_W < IN_W + 1) begin : g_bad_width
      $error("counter_mode_unit: OUT_W must be at least IN_W+1");
    end
    if (STEP < 1 || STEP >= (1 << OUT_W)) begin : g_bad_step
      $error("counter_mode_unit: STEP must satisfy 1 <= STEP < 2**OUT_W");
    end
  endgenerate

  localparam int PAD = OUT_W + 1 - IN_W;
  localparam logic [OUT_W:0] STEP_X = (OUT_W + 1)'(STEP);
`ifdef COUNTER_SATURATE_EN
  localparam logic [OUT_W-1:0] MAX_V = '1;
`endif

  mode_t            mode;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             tc_q, tc_d;
  logic             cb_q, cb_d;

  // Every arithmetic path carries one extra MSB so wrap/carry falls out as that bit.
  logic [OUT_W:0]   a_x, b_x;
  logic [OUT_W:0]   up_sum, dn_diff, add_sum;
  logic [OUT_W-1:0] sub_diff;
  logic             up_wrap, dn_wrap, sub_borrow;

  assign mode       = mode_t'(bus.sel);
  assign a_x        = {{PAD{1'b0}}, bus.a};
  assign b_x        = {{PAD{1'b0}}, bus.b};
  assign up_sum     = {1'b0, dout_q} + STEP_X;
  assign dn_diff    = {1'b0, dout_q} - STEP_X;
  assign add_sum    = a_x + b_x;
  assign sub_diff   = a_x[OUT_W-1:0] - b_x[OUT_W-1:0];
  assign up_wrap    = up_sum[OUT_W];
  assign dn_wrap    = dn_diff[OUT_W];
  assign sub_borrow = (bus.a < bus.b);

  always_comb begin
    dout_d = dout_q;
    tc_d   = 1'b0;
    cb_d   = 1'b0;
    if (bus.en) begin
      case (mode)
        MODE_CNT_UP: begin
          tc_d = up_wrap;
`ifdef COUNTER_SATURATE_EN
          dout_d = up_wrap ? MAX_V : up_sum[OUT_W-1:0];
`else
          dout_d = up_sum[OUT_W-1:0];
`endif
        end
        MODE_CNT_DN: begin
          tc_d = dn_wrap;
`ifdef COUNTER_SATURATE_EN
          dout_d = dn_wrap ? '0 : dn_diff[OUT_W-1:0];
`else
          dout_d = dn_diff[OUT_W-1:0];
`endif
        end
        MODE_ADD: begin
          dout_d = add_sum[OUT_W-1:0];
          cb_d   = add_sum[OUT_W];
        end
        MODE_SUB: begin
          cb_d = sub_borrow;
`ifdef COUNTER_SATURATE_EN
          dout_d = sub_borrow ? '0 : sub_diff;
`else
          dout_d = sub_diff;
`endif
        end
        MODE_LOAD:  dout_d = a_x[OUT_W-1:0];
        MODE_CLEAR: dout_d = '0;
        MODE_HOLD, MODE_RESV: dout_d = dout_q;
        default:    dout_d = dout_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      tc_q   <= 1'b0;
      cb_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      tc_q   <= tc_d;
      cb_q   <= cb_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.tc   = tc_q;
  assign bus.cb   = cb_q;

endmodule

// File: tb/tb_counter_mode_unit.sv
// Bench for counter_mode_unit: vector table, async-reset sequence and a random phase, all through a scoreboard.
// Honours COUNTER_SATURATE_EN so the same table covers both builds.
module tb_counter_mode_unit;
  localparam int IN_W  = 3;
  localparam int OUT_W = 4;
  localparam int STEP  = 1;
  localparam int MOD   = 1 << OUT_W;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic             en;
    logic [2:0]       sel;
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic [OUT_W-1:0] dout;
    logic             tc;
    logic             cb;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  vec_t vecs[$];
  logic [OUT_W+1:0] exp_q[$];

  counter_mode_unit_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  counter_mode_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add_vec(input logic e, input logic [2:0] s, input int av, input int bv,
                         input int d, input logic t, input logic c);
    vec_t v;
    v.en = e; v.sel = s; v.a = IN_W'(av); v.b = IN_W'(bv);
    v.dout = OUT_W'(d); v.tc = t; v.cb = c;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, queue its expectation, then compare just after the edge.
  task automatic drive(input logic e, input logic [2:0] s, input logic [IN_W-1:0] av,
                       input logic [IN_W-1:0] bv, input logic [OUT_W-1:0] ed,
                       input logic et, input logic ec, input string tag);
    logic [OUT_W+1:0] exp;
    bus.en = e; bus.sel = s; bus.a = av; bus.b = bv;
    exp_q.push_back({ed, et, ec});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_dout"}, 32'(bus.dout), 32'(exp[OUT_W+1:2]));
      check({tag, "_tc"},   32'(bus.tc),   32'(exp[1]));
      check({tag, "_cb"},   32'(bus.cb),   32'(exp[0]));
    end
    @(negedge clk);
  endtask

  function automatic logic [OUT_W+1:0] model(input int m, input logic e, input logic [2:0] s,
                                             input int av, input int bv);
    int d;
    int t;
    logic tf;
    logic cf;
    d = m; tf = 1'b0; cf = 1'b0;
    if (e) begin
      case (s)
        3'd0: begin
          t = m + STEP;
          if (t >= MOD) begin tf = 1'b1; d = SAT ? MOD - 1 : t - MOD; end
          else d = t;
        end
        3'd4: begin
          t = m - STEP;
          if (t < 0) begin tf = 1'b1; d = SAT ? 0 : t + MOD; end
          else d = t;
        end
        3'd2: begin t = av + bv; d = t % MOD; cf = (t >= MOD); end
        3'd3: begin
          if (av < bv) begin cf = 1'b1; d = SAT ? 0 : av - bv + MOD; end
          else d = av - bv;
        end
        3'd5: d = av;
        3'd6: d = 0;
        default: d = m;
      endcase
    end
    return {OUT_W'(d), tf, cf};
  endfunction

  initial begin
    logic [OUT_W+1:0] r;
    logic e;
    logic [2:0] s;
    int av, bv, m;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    bus.en = 1'b0; bus.sel = 3'd0; bus.a = '0; bus.b = '0;

    for (int i = 1; i <= 10; i++) add_vec(1, 3'd0, 0, 0, i, 0, 0);
    add_vec(1, 3'd1, 0, 0, 10, 0, 0);
    add_vec(1, 3'd1, 0, 0, 10, 0, 0);
    add_vec(1, 3'd2, 1, 3, 4, 0, 0);
    add_vec(1, 3'd2, 5, 4, 9, 0, 0);
    add_vec(1, 3'd5, 7, 0, 7, 0, 0);
    for (int i = 8; i <= 15; i++) add_vec(1, 3'd0, 0, 0, i, 0, 0);
    add_vec(1, 3'd0, 0, 0, SAT ? 15 : 0, 1, 0);
    add_vec(1, 3'd0, 0, 0, SAT ? 15 : 1, SAT, 0);
    add_vec(1, 3'd3, 2, 5, SAT ? 0 : 13, 0, 1);
    add_vec(1, 3'd3, 5, 2, 3, 0, 0);
    add_vec(1, 3'd6, 0, 0, 0, 0, 0);
    add_vec(1, 3'd4, 0, 0, SAT ? 0 : 15, 1, 0);
    add_vec(0, 3'd0, 3, 3, SAT ? 0 : 15, 0, 0);
    add_vec(1, 3'd7, 3, 3, SAT ? 0 : 15, 0, 0);
    add_vec(1, 3'd4, 0, 0, SAT ? 0 : 14, SAT, 0);
    add_vec(1, 3'd2, 7, 7, 14, 0, 0);
    add_vec(1, 3'd0, 0, 0, 15, 0, 0);

    #50;
    check("rst_async_dout", 32'(bus.dout), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_dout", 32'(bus.dout), 32'd0);
    check("rst_held_tc",   32'(bus.tc),   32'd0);
    check("rst_held_cb",   32'(bus.cb),   32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i])
      drive(vecs[i].en, vecs[i].sel, vecs[i].a, vecs[i].b,
            vecs[i].dout, vecs[i].tc, vecs[i].cb, $sformatf("vec%0d", i));

    // Asynchronous reset pulse landing between edges while counting.
    drive(1, 3'd6, 0, 0, 0, 0, 0, "pre_clr");
    for (int i = 1; i <= 6; i++) drive(1, 3'd0, 0, 0, OUT_W'(i), 0, 0, $sformatf("pre_cnt%0d", i));
    #30 rst = 1'b0;
    #1;
    check("mid_rst_dout", 32'(bus.dout), 32'd0);
    check("mid_rst_tc",   32'(bus.tc),   32'd0);
    #30 rst = 1'b1;
    drive(1, 3'd0, 0, 0, 1, 0, 0, "resume1");
    drive(1, 3'd0, 0, 0, 2, 0, 0, "resume2");

    m = 2;
    for (int i = 0; i < 60; i++) begin
      e  = ($urandom_range(0, 5) != 0);
      s  = 3'($urandom_range(0, 7));
      av = $urandom_range(0, (1 << IN_W) - 1);
      bv = $urandom_range(0, (1 << IN_W) - 1);
      r  = model(m, e, s, av, bv);
      drive(e, s, IN_W'(av), IN_W'(bv), r[OUT_W+1:2], r[1], r[0], $sformatf("rnd%0d", i));
      m = int'(r[OUT_W+1:2]);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
